// File: rtl/seg_display_scanner_if.sv
// Bundle between the value-producing logic and the display scanner.
// The producer side holds the master modport and the scanner holds the slave modport.
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic                    lz_blank;
  logic [3:0]              Binary_out;
  logic [NUM_DIGITS-1:0]   An;
  logic                    blank;
  logic [IDX_W-1:0]        digit_idx;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output load, value_in, digit_mask, lz_blank,
    input  Binary_out, An, blank, digit_idx, pending, frame_done
  );

  modport slave (
    input  load, value_in, digit_mask, lz_blank,
    output Binary_out, An, blank, digit_idx, pending, frame_done
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed scanner for an N-digit 7-segment display with active-low anodes.
// Loads go to a shadow register and are committed only at frame end, so no frame is torn.
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_scanner_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  blank_q, blank_d;

  logic                  cnt_wrap;
  logic                  frame_end;
  logic                  dark;
  logic [NUM_DIGITS-1:0] zero_above;

  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign frame_end = cnt_wrap && (idx_q == IDX_LAST);

  // Prescaler, slot index and the shadow/commit path.
  always_comb begin
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (bus.load) begin
      shadow_d = bus.value_in;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (bus.load) begin
        disp_d = bus.value_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  // zero_above[i]: nibble i and every higher nibble of the next display value are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero_above
      assign zero_above[gi] = (disp_d[VAL_W-1:4*gi] == '0);
    end
  endgenerate

  // Anodes are computed from next-state values so they line up with the counter edge.
  always_comb begin
    dark = !bus.digit_mask[idx_d] ||
           (bus.lz_blank && (idx_d != '0) && zero_above[idx_d]);
    an_d = '1;
    if ((cnt_d >= BLANK_END) && !dark) begin
      an_d[idx_d] = 1'b0;
    end
    blank_d = &an_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      blank_q   <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.Binary_out = disp_q[{idx_q, 2'b00} +: 4];
  assign bus.An         = an_q;
  assign bus.blank      = blank_q;
  assign bus.digit_idx  = idx_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_end;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed and random checks of seg_display_scanner against a cycle-count reference model.
module tb_seg_display_scanner;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_scanner_if #(.NUM_DIGITS(N)) sif ();

  seg_display_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  // Reference model: cycles since reset release, committed value, newest uncommitted load.
  int          t;
  logic [15:0] disp_m;
  logic [15:0] new_val;
  logic        have_new;
  logic [3:0]  m_mask, p_mask;
  logic        m_lz, p_lz;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
    end
  endtask

  task automatic check_all();
    int          slot;
    int          cnt;
    logic [15:0] upper;
    logic        dark;
    logic [3:0]  ea;
    slot  = (t / DIV) % N;
    cnt   = t % DIV;
    upper = disp_m >> (4 * slot);
    dark  = !p_mask[slot] || (p_lz && slot != 0 && upper == 16'h0);
    ea    = 4'hF;
    if (cnt >= BLNK && !dark) ea[slot] = 1'b0;
    chk("digit_idx", 32'(sif.digit_idx), 32'(slot));
    chk("binary_out", 32'(sif.Binary_out), 32'(upper[3:0]));
    chk("an", 32'(sif.An), 32'(ea));
    chk("blank", 32'(sif.blank), 32'(ea == 4'hF));
    chk("pending", 32'(sif.pending), 32'(have_new));
    chk("frame_done", 32'(sif.frame_done), 32'((t % FRAME) == FRAME - 1));
  endtask

  task automatic model_reset();
    t        = 0;
    disp_m   = 16'h0;
    new_val  = 16'h0;
    have_new = 1'b0;
    p_mask   = m_mask;
    p_lz     = m_lz;
  endtask

  task automatic cycle(input logic ld, input logic [15:0] v);
    logic fe;
    sif.load       = ld;
    sif.value_in   = v;
    sif.digit_mask = m_mask;
    sif.lz_blank   = m_lz;
    @(posedge clk);
    fe = ((t % FRAME) == FRAME - 1);
    if (ld) begin
      new_val  = v;
      have_new = 1'b1;
    end
    if (fe && have_new) begin
      disp_m   = new_val;
      have_new = 1'b0;
    end
    p_mask = m_mask;
    p_lz   = m_lz;
    t++;
    #1;
    sif.load = 1'b0;
    check_all();
  endtask

  task automatic run_to(input int target);
    while (t < target) cycle(1'b0, 16'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    m_mask         = 4'b1111;
    m_lz           = 1'b0;
    sif.load       = 1'b0;
    sif.value_in   = 16'h0;
    sif.digit_mask = m_mask;
    sif.lz_blank   = m_lz;
    model_reset();

    // Reset state before release
    #12;
    chk("rst_an", 32'(sif.An), 32'hF);
    chk("rst_blank", 32'(sif.blank), 32'h1);
    chk("rst_idx", 32'(sif.digit_idx), 32'h0);
    chk("rst_bin", 32'(sif.Binary_out), 32'h0);
    chk("rst_frame_done", 32'(sif.frame_done), 32'h0);
    release_reset();

    // 1/2: blank then show digit 0; load 1234 at cycle 5
    run_to(2);
    chk("s1_an_show", 32'(sif.An), 32'hE);
    run_to(5);
    cycle(1'b1, 16'h1234);
    chk("s2_pending", 32'(sif.pending), 32'h1);
    run_to(8);
    chk("s1_idx1", 32'(sif.digit_idx), 32'h1);
    run_to(31);
    chk("s2_frame_done", 32'(sif.frame_done), 32'h1);
    run_to(34);
    chk("s2_an34", 32'(sif.An), 32'hE);
    chk("s2_bin34", 32'(sif.Binary_out), 32'h4);
    run_to(58);
    chk("s2_digit3_bin", 32'(sif.Binary_out), 32'h1);
    chk("s2_digit3_an", 32'(sif.An), 32'h7);

    // 3: last load wins
    run_to(67);
    cycle(1'b1, 16'hAAAA);
    run_to(74);
    cycle(1'b1, 16'h00F0);
    run_to(106);
    chk("s3_digit1_bin", 32'(sif.Binary_out), 32'hF);
    chk("s3_digit1_an", 32'(sif.An), 32'hD);
    run_to(114);
    chk("s3_digit2_bin", 32'(sif.Binary_out), 32'h0);

    // 4: leading-zero suppression
    m_lz = 1'b1;
    run_to(128);
    cycle(1'b1, 16'h0050);
    run_to(162);
    chk("s4_digit0_an", 32'(sif.An), 32'hE);
    run_to(170);
    chk("s4_digit1_an", 32'(sif.An), 32'hD);
    chk("s4_digit1_bin", 32'(sif.Binary_out), 32'h5);
    run_to(178);
    chk("s4_digit2_dark", 32'(sif.An), 32'hF);
    run_to(186);
    chk("s4_digit3_dark", 32'(sif.An), 32'hF);
    run_to(192);
    cycle(1'b1, 16'h0000);
    run_to(226);
    chk("s4_zero_digit0", 32'(sif.An), 32'hE);
    run_to(234);
    chk("s4_zero_digit1", 32'(sif.An), 32'hF);

    // 5: digit mask
    m_lz   = 1'b0;
    m_mask = 4'b1011;
    run_to(274);
    chk("s5_masked", 32'(sif.An), 32'hF);
    run_to(279);
    chk("s5_masked_end", 32'(sif.An), 32'hF);
    run_to(280);
    chk("s5_idx3", 32'(sif.digit_idx), 32'h3);
    run_to(282);
    chk("s5_digit3_lit", 32'(sif.An), 32'h7);

    // 6: asynchronous reset mid-SHOW with a pending load
    m_mask = 4'b1111;
    run_to(290);
    cycle(1'b1, 16'hBEEF);
    run_to(301);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_an", 32'(sif.An), 32'hF);
    chk("s6_async_idx", 32'(sif.digit_idx), 32'h0);
    chk("s6_async_pending", 32'(sif.pending), 32'h0);
    chk("s6_async_bin", 32'(sif.Binary_out), 32'h0);
    @(posedge clk);
    release_reset();
    run_to(2);
    chk("s6_after_bin", 32'(sif.Binary_out), 32'h0);
    chk("s6_after_pending", 32'(sif.pending), 32'h0);
    run_to(FRAME + 4);

    // Random loads, masks and leading-zero mode, including loads on frame-end cycles
    for (int i = 0; i < 800; i++) begin
      logic        ld;
      logic [15:0] v;
      ld = ($urandom % 6) == 0;
      if ((t % FRAME) == FRAME - 1 && ($urandom % 2) == 1) ld = 1'b1;
      v = 16'($urandom);
      if (($urandom % 3) == 0) v = v & 16'h00FF;
      if (($urandom % 25) == 0) m_mask = 4'($urandom);
      if (($urandom % 40) == 0) m_lz = ~m_lz;
      cycle(ld, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
